uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the board's UART transmitter.
- Lets a host PC send command bytes to the FPGA, for example accelerometer register address and enable control.
- Oversamples the asynchronous serial line 16x, majority-votes each bit and presents each byte on a valid/ack handshake.
- Flags framing errors and overruns.

Parameters:
- CLK_HZ, 50000000, frequency of i_clk in Hz.
- BAUD, 115200, line baud rate.
- DIV, CLK_HZ/(BAUD*16) rounded to nearest (27 at defaults), clocks per oversample tick; must be >= 2.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data_rx  input  1  serial line; idles high; asynchronous to i_clk.
- i_ack_rx  input  1  consumer accepts o_data_rx when high with o_valid_rx high.
- o_data_rx  output  8  received byte, LSB = first data bit.
- o_valid_rx  output  1  o_data_rx holds an unconsumed byte.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  sticky: a byte was dropped because the previous byte was not consumed.

Behaviour:
- Reset values:
  - o_data_rx = 0x00, o_valid_rx = 0, o_frame_err = 0, o_overrun = 0.
  - Synchronizer flops = 1, state = IDLE, counters = 0.
  - Reset mid-frame abandons the frame with no output.
- Input conditioning: 2-flop synchronizer on i_data_rx. All decisions use the synchronized value, which adds 2 clocks of latency.
- Tick generator:
  - Counter div 0..DIV-1 runs only outside IDLE.
  - tick = (div == DIV-1).
  - Sample index s (4 bits, 0..15) increments on each tick and wraps 15 -> 0, marking the end of a bit period.
- Majority vote: synchronized line captured on ticks with s = 7, 8, 9. The bit value is the majority of the 3 samples, decided on the s = 9 tick.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - Synchronized line low -> START with div = 0, s = 0.
    - Otherwise stay in IDLE.
  - START:
    - On the s = 9 decision, majority 1 -> IDLE (false start, no flags).
    - Majority 0 -> continue to s wrap, then DATA with bit count = 0.
  - DATA:
    - Each decision shifts the bit into the shift register LSB-first.
    - After the 8th bit's s wrap -> STOP.
  - STOP:
    - On the s = 9 decision, majority 1: byte complete; majority 0: o_frame_err = 1 for exactly 1 clock and the byte is discarded.
    - In both cases -> IDLE in the same cycle, allowing early resync for the next start edge.
    - After a frame error, a line still low re-enters START immediately. A break condition therefore yields repeated frame errors and no bytes.
- Byte-complete handling, registered in the cycle after the decision:
  - o_valid_rx = 0, or o_valid_rx = 1 with i_ack_rx = 1 in the same cycle: load o_data_rx and set o_valid_rx = 1. No overrun.
  - o_valid_rx = 1 and i_ack_rx = 0: new byte dropped, o_data_rx unchanged, o_overrun set to 1. It stays set until i_rst.
- Handshake:
  - o_valid_rx falls in the cycle after a clock with o_valid_rx & i_ack_rx, unless a new byte loads in that same cycle.
  - i_ack_rx with o_valid_rx = 0 is ignored.
  - o_data_rx is stable while o_valid_rx = 1.
- Latency: o_valid_rx rises roughly 9.5 bit periods after the start edge on the pin. Exactly: 2 sync clocks + 1 IDLE detect clock + (9*16 + 10) ticks of DIV clocks + 1 register clock, ±1 clock.
- Line widths: shift register 8 bits, bit count 3 bits, div width = clog2(DIV).

Test Plan:
- Send 0x55 at BAUD with a bit period of exactly DIV*16 clocks, ack held high -> o_valid_rx pulses 1 clock, o_data_rx = 0x55, no flags.
- Send 0xA3 then 0x3C back-to-back, ack 5 clocks after each valid -> two valid windows, data 0xA3 then 0x3C, o_overrun = 0. Repeat with baud ±3% -> same result.
- Low glitch of 4 ticks (64*DIV/16 clocks) on an idle line -> no o_valid_rx, no o_frame_err, FSM back in IDLE before the s = 15 tick.
- Send 0x0F with the stop bit driven low -> o_frame_err high for exactly 1 clock, o_valid_rx stays 0, o_data_rx unchanged.
- Send 0x11 then 0x22 with ack held low -> o_data_rx = 0x11, o_valid_rx = 1, o_overrun = 1. Ack once -> valid drops and o_overrun stays 1.
- Assert i_rst during data bit 4 of 0x99, then send 0x77 -> no output for 0x99, o_data_rx = 0x77 valid, all flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with a 2-of-3 vote at mid-bit, and a valid/ack byte output.
// o_valid_rx rises ~9.5 bit times after the start edge; an unacked byte blocks the next one, which is dropped and flagged in o_overrun.
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_rx,
    input  logic       i_ack_rx,
    output logic [7:0] o_data_rx,
    output logic       o_valid_rx,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_s;
    logic [2:0]       r_bitcnt;
    logic [1:0]       r_samp;
    logic [7:0]       r_shift;
    logic             r_done;

    logic w_rx;
    logic w_tick;
    logic w_maj;
    logic w_decide;
    logic w_wrap;

    assign w_rx     = r_sync2;
    assign w_tick   = (r_div == DIV_W'(DIV - 1));
    assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
    assign w_decide = w_tick && (r_s == 4'd9);
    assign w_wrap   = w_tick && (r_s == 4'd15);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_data_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_s         <= '0;
            r_bitcnt    <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            o_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                r_div <= '0;
                r_s   <= '0;
                if (!w_rx) begin
                    r_state <= START;
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_s <= r_s + 4'd1;
                end
                if (w_tick && (r_s == 4'd7)) begin
                    r_samp[0] <= w_rx;
                end
                if (w_tick && (r_s == 4'd8)) begin
                    r_samp[1] <= w_rx;
                end
                case (r_state)
                    START: begin
                        if (w_decide && w_maj) begin
                            r_state <= IDLE;
                        end else if (w_wrap) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        if (w_decide) begin
                            r_shift <= {w_maj, r_shift[7:1]};
                        end
                        if (w_wrap) begin
                            if (r_bitcnt == 3'd7) begin
                                r_state <= STOP;
                            end
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    STOP: begin
                        // Leave at mid-stop so a start edge right after the stop bit is not missed.
                        if (w_decide) begin
                            r_state <= IDLE;
                            if (w_maj) begin
                                r_done <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data_rx  <= 8'h00;
            o_valid_rx <= 1'b0;
            o_overrun  <= 1'b0;
        end else if (r_done && (!o_valid_rx || i_ack_rx)) begin
            o_data_rx  <= r_shift;
            o_valid_rx <= 1'b1;
        end else if (r_done) begin
            o_overrun <= 1'b1;
        end else if (o_valid_rx && i_ack_rx) begin
            o_valid_rx <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 4 (64 clocks per bit), with a line driver, a background ack driver and an output monitor.
module tb_uart_rx;
    localparam int CLK_HZ = 7_372_800;
    localparam int BAUD   = 115_200;
    localparam int BITCLK = 64;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_data_rx;
    logic       i_ack_rx;
    logic [7:0] o_data_rx;
    logic       o_valid_rx;
    logic       o_frame_err;
    logic       o_overrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         ack_mode = 2;
    logic       man_ack = 1'b0;
    logic [7:0] rx_q[$];
    int         rise_cyc = 0;
    int         fe_cnt   = 0;
    int         vcyc     = 0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data_rx  (i_data_rx),
        .i_ack_rx   (i_ack_rx),
        .o_data_rx  (o_data_rx),
        .o_valid_rx (o_valid_rx),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bclk);
        i_data_rx = 1'b0;
        wait_clks(bclk);
        for (int i = 0; i < 8; i++) begin
            i_data_rx = b[i];
            wait_clks(bclk);
        end
        i_data_rx = stop;
        wait_clks(bclk);
        i_data_rx = 1'b1;
    endtask

    initial begin : monitor
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_valid_rx && !prev_v) begin
                rx_q.push_back(o_data_rx);
                rise_cyc = cyc;
            end
            if (o_valid_rx)  vcyc++;
            if (o_frame_err) fe_cnt++;
            prev_v = o_valid_rx;
        end
    end

    initial begin : ack_drv
        int vcnt;
        vcnt     = 0;
        i_ack_rx = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (ack_mode)
                0: i_ack_rx = 1'b1;
                1: begin
                    if (o_valid_rx && !i_ack_rx) begin
                        vcnt++;
                        if (vcnt >= 5) begin
                            i_ack_rx = 1'b1;
                            vcnt     = 0;
                        end
                    end else begin
                        i_ack_rx = 1'b0;
                    end
                end
                2: i_ack_rx = 1'b0;
                default: i_ack_rx = man_ack;
            endcase
        end
    end

    initial begin : main
        int b_q, b_v, b_fe, st, lat;
        int rates[3];
        rates = '{64, 66, 62};
        i_rst     = 1'b1;
        i_data_rx = 1'b1;
        wait_clks(5);
        check("rst_data",  o_data_rx,   8'h00);
        check("rst_valid", o_valid_rx,  1'b0);
        check("rst_ferr",  o_frame_err, 1'b0);
        check("rst_ovr",   o_overrun,   1'b0);
        i_rst = 1'b0;
        wait_clks(5);

        // Single byte, ack held high: one-clock valid pulse at the computed latency.
        ack_mode = 0;
        wait_clks(2);
        b_q = rx_q.size(); b_v = vcyc; b_fe = fe_cnt;
        st = cyc;
        send_byte(8'h55, 1'b1, BITCLK);
        wait_clks(100);
        lat = rise_cyc - st;
        check("t1_count", rx_q.size() - b_q, 1);
        check("t1_data",  rx_q[b_q], 8'h55);
        check("t1_vcyc",  vcyc - b_v, 1);
        check("t1_ferr",  fe_cnt - b_fe, 0);
        check("t1_ovr",   o_overrun, 1'b0);
        check("t1_lat",   (lat >= 619 && lat <= 621), 1'b1);

        // Back-to-back bytes with delayed ack, at nominal and +/-3% baud.
        for (int r = 0; r < 3; r++) begin
            ack_mode = 1;
            b_q = rx_q.size(); b_fe = fe_cnt;
            send_byte(8'hA3, 1'b1, rates[r]);
            send_byte(8'h3C, 1'b1, rates[r]);
            wait_clks(100);
            check("t2_count", rx_q.size() - b_q, 2);
            check("t2_data0", rx_q[b_q], 8'hA3);
            check("t2_data1", rx_q[b_q + 1], 8'h3C);
            check("t2_ovr",   o_overrun, 1'b0);
            check("t2_ferr",  fe_cnt - b_fe, 0);
        end

        // 4-tick glitch is rejected as a false start; a following byte still lands.
        ack_mode = 0;
        wait_clks(2);
        b_q = rx_q.size(); b_fe = fe_cnt;
        i_data_rx = 1'b0;
        wait_clks(16);
        i_data_rx = 1'b1;
        wait_clks(200);
        check("t3_count", rx_q.size() - b_q, 0);
        check("t3_ferr",  fe_cnt - b_fe, 0);
        send_byte(8'h5A, 1'b1, BITCLK);
        wait_clks(100);
        check("t3_after_count", rx_q.size() - b_q, 1);
        check("t3_after_data",  rx_q[b_q], 8'h5A);

        // Stop bit low: exactly one frame-error clock, byte discarded.
        b_q = rx_q.size(); b_fe = fe_cnt;
        send_byte(8'h0F, 1'b0, BITCLK);
        wait_clks(200);
        check("t4_ferr",  fe_cnt - b_fe, 1);
        check("t4_count", rx_q.size() - b_q, 0);
        check("t4_valid", o_valid_rx, 1'b0);
        check("t4_data",  o_data_rx, 8'h5A);

        // Ack held low: second byte dropped, overrun sticky across an ack.
        ack_mode = 2;
        wait_clks(2);
        send_byte(8'h11, 1'b1, BITCLK);
        wait_clks(50);
        check("t5_data1",  o_data_rx, 8'h11);
        check("t5_valid1", o_valid_rx, 1'b1);
        check("t5_ovr1",   o_overrun, 1'b0);
        send_byte(8'h22, 1'b1, BITCLK);
        wait_clks(50);
        check("t5_data2",  o_data_rx, 8'h11);
        check("t5_valid2", o_valid_rx, 1'b1);
        check("t5_ovr2",   o_overrun, 1'b1);
        man_ack  = 1'b0;
        ack_mode = 3;
        @(negedge i_clk);
        man_ack = 1'b1;
        repeat (2) @(negedge i_clk);
        man_ack = 1'b0;
        wait_clks(5);
        check("t5_valid3", o_valid_rx, 1'b0);
        check("t5_ovr3",   o_overrun, 1'b1);

        // Reset mid-frame (data bit 4), held until the frame ends, then a clean byte.
        ack_mode = 0;
        wait_clks(2);
        fork
            send_byte(8'h99, 1'b1, BITCLK);
            begin
                wait_clks(5 * BITCLK + 32);
                i_rst = 1'b1;
            end
        join
        wait_clks(5);
        check("t6_rst_valid", o_valid_rx, 1'b0);
        check("t6_rst_ovr",   o_overrun, 1'b0);
        check("t6_rst_data",  o_data_rx, 8'h00);
        i_rst = 1'b0;
        wait_clks(20);
        b_q = rx_q.size(); b_fe = fe_cnt;
        send_byte(8'h77, 1'b1, BITCLK);
        wait_clks(100);
        check("t6_count", rx_q.size() - b_q, 1);
        check("t6_data",  rx_q[b_q], 8'h77);
        check("t6_ovr",   o_overrun, 1'b0);
        check("t6_ferr",  fe_cnt - b_fe, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
